// File: rtl/lb_stencil_reader.sv
// 2x2 stencil assembler behind the line buffer, with a drop-on-full output FIFO.
// Define LBSR_STATS_EN to add saturating win_count/drop_count outputs.
module lb_stencil_reader #(
  parameter int LWIDTH     = 8,
  parameter int LINE_LEN   = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [LWIDTH-1:0]   wdata,
  input  logic                wen,
  input  logic [LWIDTH-1:0]   lb_rdata,
  input  logic                lb_valid,
  output logic [4*LWIDTH-1:0] out_window,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                overflow,
  output logic                busy
`ifdef LBSR_STATS_EN
  ,
  output logic [15:0]         win_count,
  output logic [15:0]         drop_count
`endif
);

  localparam int CW = $clog2(LINE_LEN);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int WW = 4 * LWIDTH;
  localparam logic [CW-1:0] LAST = CW'(LINE_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRIME,
    S_STREAM,
    S_DRAIN
  } state_t;

  state_t state;

  logic [CW-1:0]     col;
  logic              prev_ok;
  logic [LWIDTH-1:0] top_prev;
  logic [LWIDTH-1:0] bot_prev;

  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic [WW-1:0]     mem [FIFO_DEPTH];

  logic          form;
  logic [WW-1:0] win;
  logic          empty;
  logic          full;
  logic          pop;
  logic          push;
  logic          drop;

  assign form  = wen & lb_valid & prev_ok & (col != '0);
  assign win   = {top_prev, lb_rdata, bot_prev, wdata};
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = out_ready & ~empty;
  // A same-cycle pop frees the head slot, so a full FIFO still accepts
  assign push  = form & (~full | pop);
  assign drop  = form & full & ~pop;

  assign out_valid  = ~empty;
  assign out_window = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      col      <= '0;
      prev_ok  <= 1'b0;
      top_prev <= '0;
      bot_prev <= '0;
    end else if (wen) begin
      top_prev <= lb_rdata;
      bot_prev <= wdata;
      if (col == LAST) begin
        col     <= '0;
        prev_ok <= 1'b0;
      end else begin
        col     <= col + CW'(1);
        prev_ok <= lb_valid;
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)
        rd_ptr <= rd_ptr + (AW+1)'(1);
      if (drop)
        overflow <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (push)
      mem[wr_ptr[AW-1:0]] <= win;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= S_IDLE;
      busy  <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (wen) begin
            state <= lb_valid ? S_STREAM : S_PRIME;
            busy  <= 1'b1;
          end
        end
        S_PRIME: begin
          if (wen && lb_valid) begin
            state <= S_STREAM;
          end else if (!wen) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        S_STREAM: begin
          if (!wen && lb_valid) begin
            state <= S_DRAIN;
          end else if (!wen) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        S_DRAIN: begin
          if (!lb_valid) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else if (wen) begin
            state <= S_STREAM;
          end
        end
      endcase
    end
  end

`ifdef LBSR_STATS_EN
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      win_count  <= '0;
      drop_count <= '0;
    end else begin
      if (push && win_count != 16'hFFFF)
        win_count <= win_count + 16'd1;
      if (drop && drop_count != 16'hFFFF)
        drop_count <= drop_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_lb_stencil_reader.sv
// Bench for lb_stencil_reader: directed streams plus random traffic
// against a pixel-history reference model.
module tb_lb_stencil_reader;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [7:0]  wdata;
  logic        wen;
  logic [7:0]  lb_rdata;
  logic        lb_valid;
  logic [31:0] out_window;
  logic        out_valid;
  logic        out_ready;
  logic        overflow;
  logic        busy;
`ifdef LBSR_STATS_EN
  logic [15:0] win_count;
  logic [15:0] drop_count;
`endif

  lb_stencil_reader #(
    .LWIDTH(8),
    .LINE_LEN(8),
    .FIFO_DEPTH(4)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .wdata(wdata),
    .wen(wen),
    .lb_rdata(lb_rdata),
    .lb_valid(lb_valid),
    .out_window(out_window),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .overflow(overflow),
    .busy(busy)
`ifdef LBSR_STATS_EN
    ,
    .win_count(win_count),
    .drop_count(drop_count)
`endif
  );

  always #5 CLK = ~CLK;

  int npass = 0;
  int ntot  = 0;
  int nfail = 0;

  logic [31:0] q[$];
  logic [31:0] popped[$];
  logic [31:0] ref_win[$];
  logic [7:0]  hw[$];
  logic [7:0]  ht[$];
  bit          hv[$];
  bit          m_ovf;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pget(input int i);
    if (i < popped.size())
      return popped[i];
    return 32'hxxxxxxxx;
  endfunction

  task automatic model_clear();
    q.delete();
    hw.delete();
    ht.delete();
    hv.delete();
    m_ovf = 1'b0;
  endtask

  // Check current outputs, drive one cycle of inputs, predict the edge.
  task automatic cyc(input logic w, input logic [7:0] wd, input logic v,
                     input logic [7:0] ld, input logic r);
    int k;
    bit f;
    @(negedge CLK);
    chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
    chk("out_window", out_window, q.size() > 0 ? q[0] : 32'h0);
    chk("overflow", 32'(overflow), 32'(m_ovf));
    wen = w; wdata = wd; lb_valid = v; lb_rdata = ld; out_ready = r;
    k = hw.size();
    f = w && v && (k % 8) != 0 && hv[k-1];
    if (r && q.size() > 0)
      popped.push_back(q.pop_front());
    if (f) begin
      if (q.size() < 4)
        q.push_back({ht[k-1], ld, hw[k-1], wd});
      else
        m_ovf = 1'b1;
    end
    if (w) begin
      hw.push_back(wd);
      ht.push_back(ld);
      hv.push_back(v);
    end
  endtask

  task automatic do_reset(input bit c, input string tag);
    RESET = 1'b1;
    wen = 1'b0; lb_valid = 1'b0; out_ready = 1'b0;
    #1;
    if (c) begin
      chk({tag, "_valid"}, 32'(out_valid), 32'h0);
      chk({tag, "_window"}, out_window, 32'h0);
      chk({tag, "_ovf"}, 32'(overflow), 32'h0);
      chk({tag, "_busy"}, 32'(busy), 32'h0);
    end
    model_clear();
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
  endtask

  task automatic stream(input bit gaps, input bit rdy);
    for (int p = 0; p < 24; p++) begin
      if (gaps && (p % 3) == 2)
        cyc(1'b0, 8'hee, p >= 8, 8'hdd, rdy);
      cyc(1'b1, 8'(p), p >= 8, 8'(p - 8), rdy);
    end
  endtask

  initial begin
    RESET = 1'b0;
    wen = 1'b0; wdata = '0; lb_valid = 1'b0;
    lb_rdata = '0; out_ready = 1'b0;
    #2;
    do_reset(1'b1, "rst0");

    // continuous stream, consumer always ready, then drain
    popped.delete();
    stream(1'b0, 1'b1);
    repeat (8) cyc(1'b0, 8'h0, 1'b1, 8'h0, 1'b1);
    @(posedge CLK); #1;
    chk("drain_busy", 32'(busy), 32'h1);
    chk("drain_empty", 32'(out_valid), 32'h0);
    cyc(1'b0, 8'h0, 1'b0, 8'h0, 1'b1);
    @(posedge CLK); #1;
    chk("idle_busy", 32'(busy), 32'h0);
    chk("win_total", popped.size(), 32'd14);
    chk("win_first", pget(0), 32'h00010809);
    chk("win_line0_end", pget(6), 32'h06070e0f);
    chk("win_line1_start", pget(7), 32'h08091011);
    ref_win = popped;

    // consumer stalled: four held, later windows dropped
    do_reset(1'b0, "rst1");
    popped.delete();
    stream(1'b0, 1'b0);
    @(posedge CLK); #1;
    chk("stall_valid", 32'(out_valid), 32'h1);
    chk("stall_ovf", 32'(overflow), 32'h1);
    repeat (5) cyc(1'b0, 8'h0, 1'b0, 8'h0, 1'b1);
    @(posedge CLK); #1;
    chk("stall_ovf_sticky", 32'(overflow), 32'h1);
    chk("stall_held", popped.size(), 32'd4);
    chk("stall_last", pget(3), 32'h03040b0c);
    for (int i = 0; i < 4; i++)
      cyc(1'b1, 8'h40 + 8'(i), 1'b1, 8'h50 + 8'(i), 1'b0);
    @(posedge CLK); #3;
    do_reset(1'b1, "rst_mid");

    // full FIFO with simultaneous push and pop
    popped.delete();
    for (int p = 0; p < 13; p++)
      cyc(1'b1, 8'(p), p >= 8, 8'(p - 8), 1'b0);
    cyc(1'b1, 8'd13, 1'b1, 8'd5, 1'b1);
    repeat (6) cyc(1'b0, 8'h0, 1'b0, 8'h0, 1'b1);
    @(posedge CLK); #1;
    chk("pp_ovf", 32'(overflow), 32'h0);
    chk("pp_count", popped.size(), 32'd5);
    chk("pp_last", pget(4), 32'h04050c0d);

    // wen gaps must yield the same windows in order
    do_reset(1'b0, "rst2");
    popped.delete();
    stream(1'b1, 1'b1);
    repeat (3) cyc(1'b0, 8'h0, 1'b0, 8'h0, 1'b1);
    chk("gap_total", popped.size(), 32'd14);
    for (int i = 0; i < 14; i++)
      chk($sformatf("gap_win%0d", i), pget(i), ref_win[i]);

    // random traffic against the model
    do_reset(1'b0, "rst3");
    popped.delete();
    for (int i = 0; i < 400; i++)
      cyc(($urandom % 4) != 0, 8'($urandom), ($urandom % 5) != 0,
          8'($urandom), ($urandom % 3) != 0);
    repeat (8) cyc(1'b0, 8'h0, 1'b0, 8'h0, 1'b1);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
